flush_evaluator: RTL and testbench
==================================

Name: flush_evaluator

Overview:
- Sequential, parametrised flush detector for the poker showdown datapath.
- Accepts a stream of NUM_CARDS cards, one per accepted handshake, and keeps a per-suit distinct-rank mask.
- After the last card it selects the flush suit and scans that suit's mask to produce the top FLUSH_LEN ranks, highest first, for tie-breaking.
- Sits between the card dealer/hand sequencer and the hand-ranking comparator.

Parameters:
- NUM_CARDS, 7, cards per evaluation (2..15).
- FLUSH_LEN, 5, minimum same-suit distinct ranks that form a flush (1..13).
- NUM_SUITS, 4, suit count; flower width is $clog2(NUM_SUITS), 2 at default.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a new evaluation; honoured only in IDLE.
- card_valid  in  1  card_number/card_flower are valid this cycle.
- card_ready  out  1  high in LOAD only.
- card_number  in  4  0 = Ace, 1..12 = 2..K.
- card_flower  in  SW  suit index, SW = $clog2(NUM_SUITS).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when results become valid.
- is_flush  out  1  a flush exists.
- flush_suit  out  SW  suit of the selected flush.
- flush_max_num  out  4  highest rank of the flush, 13 = Ace.
- flush_ranks  out  4*FLUSH_LEN  top FLUSH_LEN ranks of the flush suit; rank 0 in the MSB nibble, highest first.
- card_err  out  1  sticky per evaluation: an invalid or duplicate card was seen.

Behaviour:
- Reset and interface:
  - Reset is synchronous and active-high on clk, with one clock.
  - Reset has priority over everything, including mid-evaluation: FSM goes to IDLE; all masks, counters and outputs clear to 0; any partial stream is discarded.
- Rank mapping: number 0 maps to rank 13; numbers 1..12 map to ranks 1..12. The mask has 13 bits per suit, bit r-1 for rank r.
- FSM IDLE:
  - card_ready = 0.
  - start = 1: clear all suit masks, the card counter and card_err; go to LOAD.
  - Result outputs hold their last values.
- FSM LOAD:
  - card_ready = 1. A card is accepted when card_valid && card_ready.
  - Each accepted card increments the card counter (width $clog2(NUM_CARDS+1)).
  - Card with number > 12: counted, not recorded, sets card_err.
  - Card with an already-set mask bit: counted, mask unchanged, sets card_err.
  - When the counter reaches NUM_CARDS, go to SELECT the following cycle; the final card's mask update lands in the same edge.
  - start is ignored in LOAD.
- FSM SELECT (1 cycle):
  - For each suit, compute popcount(mask) and the highest set bit.
  - Qualifying suit: popcount >= FLUSH_LEN.
  - If several qualify, choose the one with the highest top rank; ties go to the lowest suit index.
  - No qualifier: is_flush = 0, flush_suit = 0, flush_max_num = 0, flush_ranks = 0; go to DONE.
  - Qualifier found: latch the suit and its mask into the scan register; clear flush_ranks; go to SCAN.
- FSM SCAN (exactly 13 cycles, scan rank r = 13 down to 1):
  - If mask bit r-1 is set and fewer than FLUSH_LEN ranks are captured, write r into the next slot.
  - The first capture also sets flush_max_num.
  - No early exit, so latency is fixed.
  - After r = 1, go to DONE.
- FSM DONE (1 cycle):
  - done = 1; is_flush is set from the selection result.
  - Outputs are valid from this cycle and are held until the next start.
  - Go to IDLE.
- Latency, last card accepted at edge t:
  - No flush: done at t+2.
  - Flush: done at t+15.
- Throughput: start is accepted in the IDLE cycle following DONE. start asserted in the DONE cycle is ignored.
- Stalls: card_valid low in LOAD stalls indefinitely; there is no timeout.

Decomposition:
- Package poker_pkg holds:
  - Shared with the card dealer and hand ranker: CARD_NUM_W=4, RANK_ACE=13, NUM_RANKS=13, card number/flower typedefs.
  - Local to this block: FSM state enum {IDLE, LOAD, SELECT, SCAN, DONE}.
- One sub-module, suit_mask_stats: combinational popcount plus highest-set-bit of a 13-bit mask, instantiated NUM_SUITS times for SELECT.

Test Plan:
- Hearts(1) A,K,9,5,2 plus spades 3,4 -> done at t+15; is_flush=1, flush_suit=1, flush_max_num=13, flush_ranks={13,12,8,4,1}.
- Rainbow hand with at most 2 cards per suit -> done at t+2; is_flush=0; all result fields 0; card_err=0.
- 7 clubs(0) ranks 2..8, input numbers 1..7 -> flush_ranks={7,6,5,4,3}, i.e. the top 5 only; flush_max_num=7.
- Card with number 14, then a duplicate hearts 5 (4 distinct hearts total) -> card_err=1, is_flush=0, card counter reaches 7.
- NUM_CARDS=10, FLUSH_LEN=5, two 5-card suits (top ranks Q and K) -> the K suit is selected; with equal top ranks, the lower suit index wins.
- Reset asserted after 3 cards, then start with card_valid held low for 4 cycles before the stream -> state IDLE, outputs 0 the cycle after reset; card_ready stays high while stalled; the following full evaluation is correct.

Source files
------------

// File: rtl/poker_pkg.sv
// Shared poker datapath types and constants, plus the flush evaluator FSM encoding.
package poker_pkg;

   localparam int CARD_NUM_W    = 4;
   localparam int NUM_RANKS     = 13;
   localparam int RANK_ACE      = 13;
   localparam int MAX_CARD_NUM  = 12;
   localparam int DEF_NUM_SUITS = 4;
   localparam int FLOWER_W      = $clog2(DEF_NUM_SUITS);

   typedef logic [CARD_NUM_W-1:0] card_num_t;
   typedef logic [FLOWER_W-1:0]   card_flower_t;
   typedef logic [NUM_RANKS-1:0]  rank_mask_t;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SELECT,
      SCAN,
      DONE
   } state_t;

   // Ace is dealt as number 0 but ranks above King.
   function automatic card_num_t num_to_rank(input card_num_t num);
      return (num == '0) ? card_num_t'(RANK_ACE) : num;
   endfunction

endpackage

// File: rtl/suit_mask_stats.sv
// Popcount and highest set rank (1..13, 0 when empty) of one suit's rank mask.
module suit_mask_stats
   import poker_pkg::*;
(
   input  logic [NUM_RANKS-1:0]  mask,
   output logic [CARD_NUM_W-1:0] pop_count,
   output logic [CARD_NUM_W-1:0] top_rank
);

   // NOTE: every output gets a default before the loop so no latch is inferred.
   always_comb begin
      pop_count = '0;
      top_rank  = '0;
      for (int i = 0; i < NUM_RANKS; i++) begin
         if (mask[i]) begin
            pop_count = pop_count + 1'b1;
            top_rank  = CARD_NUM_W'(i + 1);
         end
      end
   end

endmodule

// File: rtl/flush_evaluator.sv
// Streams NUM_CARDS cards into per-suit rank masks, picks the flush suit and
// scans its mask from Ace downwards to report the top FLUSH_LEN ranks.
module flush_evaluator
   import poker_pkg::*;
#(
   parameter int  NUM_CARDS = 7,
   parameter int  FLUSH_LEN = 5,
   parameter int  NUM_SUITS = 4,
   localparam int SW        = $clog2(NUM_SUITS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   card_valid,
   output logic                   card_ready,
   input  logic [CARD_NUM_W-1:0]  card_number,
   input  logic [SW-1:0]          card_flower,
   output logic                   busy,
   output logic                   done,
   output logic                   is_flush,
   output logic [SW-1:0]          flush_suit,
   output logic [CARD_NUM_W-1:0]  flush_max_num,
   output logic [4*FLUSH_LEN-1:0] flush_ranks,
   output logic                   card_err
);

   localparam int CNT_W = $clog2(NUM_CARDS + 1);
   localparam int CAP_W = $clog2(FLUSH_LEN + 1);

   state_t                  state;
   rank_mask_t              suit_mask [NUM_SUITS];
   logic [CNT_W-1:0]        card_cnt;
   rank_mask_t              scan_mask;
   logic [CARD_NUM_W-1:0]   scan_rank;
   logic [CAP_W-1:0]        cap_cnt;

   logic [CARD_NUM_W-1:0]   suit_pop [NUM_SUITS];
   logic [CARD_NUM_W-1:0]   suit_top [NUM_SUITS];

   logic                    sel_found;
   logic [SW-1:0]           sel_suit;
   logic [CARD_NUM_W-1:0]   sel_top;

   logic [CARD_NUM_W-1:0]   card_rank;
   logic [CARD_NUM_W-1:0]   card_bit;
   logic                    card_bad;
   logic                    card_dup;
   logic                    card_accept;

   for (genvar s = 0; s < NUM_SUITS; s++) begin : g_stats
      suit_mask_stats u_stats (
         .mask      (suit_mask[s]),
         .pop_count (suit_pop[s]),
         .top_rank  (suit_top[s])
      );
   end

   // Highest top rank wins; strict compare keeps the lowest suit on ties.
   always_comb begin
      sel_found = 1'b0;
      sel_suit  = '0;
      sel_top   = '0;
      for (int s = 0; s < NUM_SUITS; s++) begin
         if (int'(suit_pop[s]) >= FLUSH_LEN && (!sel_found || suit_top[s] > sel_top)) begin
            sel_found = 1'b1;
            sel_suit  = SW'(s);
            sel_top   = suit_top[s];
         end
      end
   end

   always_comb begin
      card_rank = num_to_rank(card_number);
      card_bit  = card_rank - 1'b1;
      card_bad  = (card_number > CARD_NUM_W'(MAX_CARD_NUM)) || (int'(card_flower) >= NUM_SUITS);
      card_dup  = !card_bad && suit_mask[card_flower][card_bit];
   end

   assign card_ready  = (state == LOAD);
   assign busy        = (state != IDLE);
   assign done        = (state == DONE);
   assign card_accept = card_valid && card_ready;

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         card_cnt      <= '0;
         scan_mask     <= '0;
         scan_rank     <= '0;
         cap_cnt       <= '0;
         is_flush      <= 1'b0;
         flush_suit    <= '0;
         flush_max_num <= '0;
         flush_ranks   <= '0;
         card_err      <= 1'b0;
         // NOTE: the suit masks are a handful of flops, not a RAM, so they are
         // reset like any other state to discard a partial stream.
         for (int s = 0; s < NUM_SUITS; s++) suit_mask[s] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  for (int s = 0; s < NUM_SUITS; s++) suit_mask[s] <= '0;
                  card_cnt <= '0;
                  card_err <= 1'b0;
                  state    <= LOAD;
               end
            end

            LOAD: begin
               if (card_accept) begin
                  card_cnt <= card_cnt + 1'b1;
                  if (card_bad || card_dup) card_err <= 1'b1;
                  else                      suit_mask[card_flower][card_bit] <= 1'b1;
                  if (card_cnt == CNT_W'(NUM_CARDS - 1)) state <= SELECT;
               end
            end

            SELECT: begin
               is_flush      <= 1'b0;
               flush_max_num <= '0;
               flush_ranks   <= '0;
               if (sel_found) begin
                  flush_suit <= sel_suit;
                  scan_mask  <= suit_mask[sel_suit];
                  scan_rank  <= CARD_NUM_W'(RANK_ACE);
                  cap_cnt    <= '0;
                  state      <= SCAN;
               end else begin
                  flush_suit <= '0;
                  state      <= DONE;
               end
            end

            // Fixed 13-cycle walk from Ace down to rank 1; no early exit.
            SCAN: begin
               if (scan_mask[scan_rank - 1'b1] && int'(cap_cnt) < FLUSH_LEN) begin
                  for (int k = 0; k < FLUSH_LEN; k++) begin
                     if (int'(cap_cnt) == k) flush_ranks[4*(FLUSH_LEN-1-k) +: 4] <= scan_rank;
                  end
                  if (cap_cnt == '0) flush_max_num <= scan_rank;
                  cap_cnt <= cap_cnt + 1'b1;
               end
               scan_rank <= scan_rank - 1'b1;
               if (scan_rank == CARD_NUM_W'(1)) begin
                  is_flush <= 1'b1;
                  state    <= DONE;
               end
            end

            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_flush_evaluator.sv
// Scoreboard bench for flush_evaluator: a 7-card instance and a 10-card instance.
module tb_flush_evaluator;
   import poker_pkg::*;

   typedef struct {
      logic        is_flush;
      logic [1:0]  suit;
      logic [3:0]  max_num;
      logic [19:0] ranks;
      logic        err;
      int          lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        start_a = 0, valid_a = 0, ready_a, busy_a, done_a, flush_a, err_a;
   logic [3:0]  num_a = 0, max_a;
   logic [1:0]  flw_a = 0, suit_a;
   logic [19:0] ranks_a;

   logic        start_b = 0, valid_b = 0, ready_b, busy_b, done_b, flush_b, err_b;
   logic [3:0]  num_b = 0, max_b;
   logic [1:0]  flw_b = 0, suit_b;
   logic [19:0] ranks_b;

   flush_evaluator #(.NUM_CARDS(7), .FLUSH_LEN(5), .NUM_SUITS(4)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .card_valid(valid_a), .card_ready(ready_a),
      .card_number(num_a), .card_flower(flw_a), .busy(busy_a), .done(done_a),
      .is_flush(flush_a), .flush_suit(suit_a), .flush_max_num(max_a),
      .flush_ranks(ranks_a), .card_err(err_a)
   );

   flush_evaluator #(.NUM_CARDS(10), .FLUSH_LEN(5), .NUM_SUITS(4)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .card_valid(valid_b), .card_ready(ready_b),
      .card_number(num_b), .card_flower(flw_b), .busy(busy_b), .done(done_b),
      .is_flush(flush_b), .flush_suit(suit_b), .flush_max_num(max_b),
      .flush_ranks(ranks_b), .card_err(err_b)
   );

   int   errors = 0;
   int   checks = 0;
   exp_t sb_q[$];
   int   hand_num[16];
   int   hand_flw[16];
   int   hand_len;
   int   last_acc;

   task automatic add(input int num, input int flw);
      hand_num[hand_len] = num;
      hand_flw[hand_len] = flw;
      hand_len++;
   endtask

   // Reference: distinct ranks per suit, best suit by top rank, top five from Ace down.
   function automatic exp_t model_hand();
      exp_t e;
      bit   seen [4][14];
      int   best, best_top, r, k, cnt, top;
      e = '{is_flush: 0, suit: 0, max_num: 0, ranks: 0, err: 0, lat: 1};
      for (int s = 0; s < 4; s++) for (int j = 0; j < 14; j++) seen[s][j] = 0;
      for (int i = 0; i < hand_len; i++) begin
         if (hand_num[i] > 12) e.err = 1;
         else begin
            r = (hand_num[i] == 0) ? 13 : hand_num[i];
            if (seen[hand_flw[i]][r]) e.err = 1;
            else seen[hand_flw[i]][r] = 1;
         end
      end
      best = -1; best_top = 0;
      for (int s = 0; s < 4; s++) begin
         cnt = 0; top = 0;
         for (int j = 1; j <= 13; j++) if (seen[s][j]) begin cnt++; top = j; end
         if (cnt >= 5 && (best < 0 || top > best_top)) begin best = s; best_top = top; end
      end
      if (best >= 0) begin
         e.is_flush = 1; e.suit = 2'(best); e.lat = 14; k = 0;
         for (int j = 13; j >= 1; j--) begin
            if (seen[best][j] && k < 5) begin
               e.ranks[4*(4-k) +: 4] = 4'(j);
               if (k == 0) e.max_num = 4'(j);
               k++;
            end
         end
      end
      return e;
   endfunction

   function automatic exp_t observe(input bit sel);
      exp_t o;
      o.is_flush = sel ? flush_b : flush_a;
      o.suit     = sel ? suit_b  : suit_a;
      o.max_num  = sel ? max_b   : max_a;
      o.ranks    = sel ? ranks_b : ranks_a;
      o.err      = sel ? err_b   : err_a;
      o.lat      = 0;
      return o;
   endfunction

   // All tasks start and end just after a falling edge.
   task automatic do_start(input bit sel);
      if (sel) start_b = 1; else start_a = 1;
      @(negedge clk);
      start_a = 0; start_b = 0;
   endtask

   task automatic send_card(input bit sel, input int num, input int flw, output bit ok);
      bit r;
      ok = 0;
      if (sel) begin valid_b = 1; num_b = 4'(num); flw_b = 2'(flw); end
      else     begin valid_a = 1; num_a = 4'(num); flw_a = 2'(flw); end
      for (int i = 0; i < 50 && !ok; i++) begin
         r = sel ? ready_b : ready_a;
         @(negedge clk);
         if (r) begin ok = 1; last_acc = cyc; end
      end
      valid_a = 0; valid_b = 0;
   endtask

   task automatic run_hand(input bit sel, input bit skip_start, input bit start_in_done);
      exp_t e, o;
      bit   ok, got;
      int   lat;
      sb_q.push_back(model_hand());
      if (!skip_start) do_start(sel);
      for (int i = 0; i < hand_len; i++) begin
         send_card(sel, hand_num[i], hand_flw[i], ok);
         if (!ok) begin
            checks++; errors++;
            $display("FAIL card_accept: card %0d not accepted within 50 cycles", i);
         end
      end
      got = 0; lat = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (sel ? done_b : done_a) begin got = 1; lat = cyc - last_acc; end
      end
      e = sb_q.pop_front();
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL done_timeout: got no done pulse, required one");
         return;
      end
      o = observe(sel);
      if (lat !== e.lat) begin errors++; $display("FAIL latency: got %0d required %0d", lat, e.lat); end
      checks++;
      if (o.is_flush !== e.is_flush) begin errors++; $display("FAIL is_flush: got %0d required %0d", o.is_flush, e.is_flush); end
      checks++;
      if (o.suit !== e.suit) begin errors++; $display("FAIL flush_suit: got %0d required %0d", o.suit, e.suit); end
      checks++;
      if (o.max_num !== e.max_num) begin errors++; $display("FAIL flush_max_num: got %0d required %0d", o.max_num, e.max_num); end
      checks++;
      if (o.ranks !== e.ranks) begin errors++; $display("FAIL flush_ranks: got %h required %h", o.ranks, e.ranks); end
      checks++;
      if (o.err !== e.err) begin errors++; $display("FAIL card_err: got %0d required %0d", o.err, e.err); end
      if (start_in_done) begin if (sel) start_b = 1; else start_a = 1; end
      @(negedge clk);
      o = observe(sel);
      checks++;
      if ((sel ? {done_b, busy_b} : {done_a, busy_a}) !== 2'b00) begin
         errors++;
         $display("FAIL after_done: got done,busy=%b required 00", sel ? {done_b, busy_b} : {done_a, busy_a});
      end
      checks++;
      if (o.ranks !== e.ranks || o.is_flush !== e.is_flush) begin
         errors++;
         $display("FAIL hold_idle: got ranks %h flush %0d required %h %0d", o.ranks, o.is_flush, e.ranks, e.is_flush);
      end
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (2) @(negedge clk);
      checks++;
      if ({ready_a, busy_a, done_a, flush_a, suit_a, max_a, ranks_a, err_a} !== '0) begin
         errors++; $display("FAIL reset_a: got nonzero outputs, required all 0");
      end
      checks++;
      if ({ready_b, busy_b, done_b, flush_b, suit_b, max_b, ranks_b, err_b} !== '0) begin
         errors++; $display("FAIL reset_b: got nonzero outputs, required all 0");
      end
      rst = 0;
      @(negedge clk);
   endtask

   task automatic test_flush_hearts();
      hand_len = 0;
      add(0, 1); add(12, 1); add(8, 1); add(4, 1); add(1, 1); add(2, 3); add(3, 3);
      run_hand(0, 0, 0);
      checks++;
      if ({suit_a, max_a, ranks_a} !== {2'd1, 4'd13, 4'd13, 4'd12, 4'd8, 4'd4, 4'd1}) begin
         errors++; $display("FAIL hearts_const: got %0d/%0d/%h required 1/13/dc841", suit_a, max_a, ranks_a);
      end
   endtask

   task automatic test_no_flush();
      hand_len = 0;
      add(0, 0); add(5, 0); add(1, 1); add(7, 1); add(3, 2); add(9, 2); add(11, 3);
      run_hand(0, 0, 0);
   endtask

   task automatic test_top_five();
      hand_len = 0;
      for (int i = 1; i <= 7; i++) add(i, 0);
      run_hand(0, 0, 0);
      checks++;
      if ({max_a, ranks_a} !== {4'd7, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3}) begin
         errors++; $display("FAIL top_five_const: got %0d/%h required 7/76543", max_a, ranks_a);
      end
   endtask

   task automatic test_card_err();
      hand_len = 0;
      add(1, 1); add(4, 1); add(8, 1); add(12, 1); add(14, 0); add(4, 1); add(2, 0);
      run_hand(0, 0, 0);
   endtask

   task automatic test_ten_cards();
      hand_len = 0;
      add(11, 0); add(9, 0); add(7, 0); add(5, 0); add(3, 0);
      add(12, 2); add(10, 2); add(8, 2); add(6, 2); add(4, 2);
      run_hand(1, 0, 0);
      checks++;
      if ({suit_b, max_b} !== {2'd2, 4'd12}) begin
         errors++; $display("FAIL ten_higher: got suit %0d max %0d required 2 12", suit_b, max_b);
      end
      hand_len = 0;
      add(12, 3); add(5, 3); add(6, 3); add(7, 3); add(8, 3);
      add(12, 1); add(1, 1); add(2, 1); add(3, 1); add(4, 1);
      run_hand(1, 0, 0);
      checks++;
      if ({suit_b, ranks_b} !== {2'd1, 4'd12, 4'd4, 4'd3, 4'd2, 4'd1}) begin
         errors++; $display("FAIL ten_tie: got suit %0d ranks %h required 1 c4321", suit_b, ranks_b);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      do_start(0);
      send_card(0, 14, 0, ok);
      send_card(0, 3, 2, ok);
      send_card(0, 6, 1, ok);
      rst = 1;
      @(negedge clk);
      rst = 0;
      checks++;
      if ({ready_a, busy_a, done_a, flush_a, suit_a, max_a, ranks_a, err_a} !== '0) begin
         errors++; $display("FAIL mid_reset: got busy %0d ready %0d err %0d flush %0d, required all 0",
                            busy_a, ready_a, err_a, flush_a);
      end
      do_start(0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({ready_a, busy_a} !== 2'b11) begin
            errors++; $display("FAIL stall_ready: got ready,busy=%b required 11 at stall %0d", {ready_a, busy_a}, i);
         end
         @(negedge clk);
      end
      hand_len = 0;
      add(10, 3); add(0, 3); add(6, 3); add(2, 3); add(9, 3); add(11, 0); add(10, 2);
      run_hand(0, 1, 0);
   endtask

   task automatic test_back_to_back();
      hand_len = 0;
      add(0, 2); add(1, 2); add(2, 2); add(3, 2); add(4, 2); add(5, 0); add(6, 1);
      run_hand(0, 0, 1);
      @(negedge clk);
      start_a = 0;
      checks++;
      if (busy_a !== 1'b1) begin
         errors++; $display("FAIL start_after_done: got busy %0d required 1", busy_a);
      end
      hand_len = 0;
      add(12, 0); add(11, 0); add(10, 0); add(9, 0); add(8, 1); add(8, 2); add(8, 3);
      run_hand(0, 1, 0);
   endtask

   initial begin
      test_reset();
      test_flush_hearts();
      test_no_flush();
      test_top_five();
      test_card_err();
      test_ten_cards();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
